// File: rtl/i2c_bit_sequencer_pkg.sv
// Shared types for the I2C bit sequencer: command encodings, quarter/FSM enums
// and the per-quarter SCL/SDA drive tables (bit q of each table = quarter q).
package i2c_bit_sequencer_pkg;

    typedef enum logic [1:0] {
        CMD_START = 2'd0,
        CMD_STOP  = 2'd1,
        CMD_WRITE = 2'd2,
        CMD_READ  = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quarter_e;

    typedef enum logic {ST_IDLE, ST_RUN} state_e;

    typedef struct packed {
        logic scl_oe;
        logic sda_oe;
    } drive_t;

    // 1 = pull the line low in that quarter; WRITE SDA follows the data bit instead.
    localparam logic [3:0] START_SCL = 4'b1000;
    localparam logic [3:0] START_SDA = 4'b1100;
    localparam logic [3:0] STOP_SCL  = 4'b0001;
    localparam logic [3:0] STOP_SDA  = 4'b0111;
    localparam logic [3:0] DATA_SCL  = 4'b1001;
    localparam logic [3:0] READ_SDA  = 4'b0000;

    function automatic drive_t drive_for(cmd_e c, logic din, quarter_e q);
        drive_t d;
        // NOTE: assign a default before the case so no path leaves d unassigned;
        // the same habit in always_comb blocks is what keeps latches from being inferred.
        d = '0;
        case (c)
            CMD_START: begin
                d.scl_oe = START_SCL[q];
                d.sda_oe = START_SDA[q];
            end
            CMD_STOP: begin
                d.scl_oe = STOP_SCL[q];
                d.sda_oe = STOP_SDA[q];
            end
            CMD_WRITE: begin
                d.scl_oe = DATA_SCL[q];
                d.sda_oe = ~din;
            end
            default: begin
                d.scl_oe = DATA_SCL[q];
                d.sda_oe = READ_SDA[q];
            end
        endcase
        return d;
    endfunction

    function automatic quarter_e next_quarter(quarter_e q);
        case (q)
            Q0:      return Q1;
            Q1:      return Q2;
            Q2:      return Q3;
            default: return Q0;
        endcase
    endfunction

endpackage

// File: rtl/i2c_bit_sequencer_if.sv
// Command/response link between the byte-level controller (master) and the
// bit sequencer (slave).
interface i2c_bit_sequencer_if;
    import i2c_bit_sequencer_pkg::*;

    logic cmd_valid;
    logic cmd_ready;
    cmd_e cmd;
    logic cmd_din;
    logic rsp_valid;
    logic rsp_dout;
    logic arb_lost;
    logic bus_busy;

    modport master (
        output cmd_valid, cmd, cmd_din,
        input  cmd_ready, rsp_valid, rsp_dout, arb_lost, bus_busy
    );

    modport slave (
        input  cmd_valid, cmd, cmd_din,
        output cmd_ready, rsp_valid, rsp_dout, arb_lost, bus_busy
    );

endinterface

// File: rtl/i2c_bit_sequencer_quarter_tick.sv
// Quarter-bit prescaler: counts 0..div and emits a tick on the terminal count;
// freezes while the slave stretches SCL.
module i2c_bit_sequencer_quarter_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             reset,
    input  logic             clear,
    input  logic             run,
    input  logic             hold,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = run && !hold && (cnt == div);

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run && !hold) begin
            cnt <= tick ? '0 : cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/i2c_bit_sequencer.sv
// I2C bit-level sequencer: runs one START/STOP/WRITE/READ command as four
// quarter-bit phases, driving open-drain SCL/SDA enables.
module i2c_bit_sequencer
    import i2c_bit_sequencer_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic                clk_i,
    input  logic                reset,
    input  logic                enable,
    input  logic [DIV_W-1:0]    clk_div,
    i2c_bit_sequencer_if.slave  bus,
    input  logic                scl_i,
    input  logic                sda_i,
    output logic                scl_oe,
    output logic                sda_oe
);

    state_e           state;
    quarter_e         quarter;
    cmd_e             cmd_q;
    logic             din_q;
    logic [DIV_W-1:0] div_q;
    logic             ready_en;
    logic             rsp_valid_q;
    logic             rsp_dout_q;
    logic             arb_lost_q;
    logic             bus_busy_q;

    logic   cmd_ready;
    logic   accept;
    logic   run;
    logic   hold;
    logic   tick;
    logic   arb_hit;
    drive_t drv_first;
    drive_t drv_next;

    // ready_en keeps cmd_ready low while reset is asserted and for the release edge.
    assign cmd_ready = ready_en && (state == ST_IDLE) && enable;
    assign accept    = bus.cmd_valid && cmd_ready;
    assign run       = (state == ST_RUN);

    // A slave holding SCL low while we have released it stretches the high phase.
    assign hold = run && ((quarter == Q1) || (quarter == Q2)) && !scl_oe && !scl_i;

    assign arb_hit   = (quarter == Q2) && (cmd_q == CMD_WRITE) && din_q && !sda_i;
    assign drv_first = drive_for(bus.cmd, bus.cmd_din, Q0);
    assign drv_next  = drive_for(cmd_q, din_q, next_quarter(quarter));

    i2c_bit_sequencer_quarter_tick #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clk_i (clk_i),
        .reset (reset),
        .clear (accept || !enable),
        .run   (run),
        .hold  (hold),
        .div   (div_q),
        .tick  (tick)
    );

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            quarter     <= Q0;
            cmd_q       <= CMD_START;
            din_q       <= 1'b0;
            div_q       <= '0;
            ready_en    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dout_q  <= 1'b0;
            arb_lost_q  <= 1'b0;
            bus_busy_q  <= 1'b0;
            scl_oe      <= 1'b0;
            sda_oe      <= 1'b0;
        end else begin
            ready_en    <= 1'b1;
            rsp_valid_q <= 1'b0;
            arb_lost_q  <= 1'b0;
            if (!enable) begin
                state      <= ST_IDLE;
                quarter    <= Q0;
                scl_oe     <= 1'b0;
                sda_oe     <= 1'b0;
                bus_busy_q <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            state      <= ST_RUN;
                            quarter    <= Q0;
                            cmd_q      <= bus.cmd;
                            din_q      <= bus.cmd_din;
                            div_q      <= clk_div;
                            rsp_dout_q <= 1'b0;
                            scl_oe     <= drv_first.scl_oe;
                            sda_oe     <= drv_first.sda_oe;
                        end
                    end
                    default: begin
                        if (tick) begin
                            if (quarter == Q3) begin
                                // Lines keep their Q3 drive: the bus stays parked in IDLE.
                                state       <= ST_IDLE;
                                quarter     <= Q0;
                                rsp_valid_q <= 1'b1;
                                if (cmd_q == CMD_START) bus_busy_q <= 1'b1;
                                if (cmd_q == CMD_STOP)  bus_busy_q <= 1'b0;
                            end else if (arb_hit) begin
                                state      <= ST_IDLE;
                                quarter    <= Q0;
                                arb_lost_q <= 1'b1;
                                bus_busy_q <= 1'b0;
                                scl_oe     <= 1'b0;
                                sda_oe     <= 1'b0;
                            end else begin
                                if ((quarter == Q2) && (cmd_q == CMD_READ)) begin
                                    rsp_dout_q <= sda_i;
                                end
                                quarter <= next_quarter(quarter);
                                scl_oe  <= drv_next.scl_oe;
                                sda_oe  <= drv_next.sda_oe;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_dout  = rsp_dout_q;
    assign bus.arb_lost  = arb_lost_q;
    assign bus.bus_busy  = bus_busy_q;

endmodule

// File: tb/tb_i2c_bit_sequencer.sv
// Directed bench for i2c_bit_sequencer: wired-AND bus model, hand-computed
// latencies and per-quarter SCL/SDA drive values.
module tb_i2c_bit_sequencer;
    import i2c_bit_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] clk_div;
    logic        scl_oe;
    logic        sda_oe;
    logic        scl_ext;
    logic        sda_ext;
    logic        scl_i;
    logic        sda_i;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int c_acc       = 0;
    int lat;
    logic got_rsp;
    logic got_arb;
    logic got_dout;
    logic [1:0] tr[$];

    i2c_bit_sequencer_if bus ();

    i2c_bit_sequencer #(
        .DIV_W (16)
    ) dut (
        .clk_i   (clk),
        .reset   (reset),
        .enable  (enable),
        .clk_div (clk_div),
        .bus     (bus),
        .scl_i   (scl_i),
        .sda_i   (sda_i),
        .scl_oe  (scl_oe),
        .sda_oe  (sda_oe)
    );

    // Open-drain bus: a line is high only if neither we nor the far side pull it.
    assign scl_i = ~scl_oe & scl_ext;
    assign sda_i = ~sda_oe & sda_ext;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input cmd_e c, input logic d, input logic [15:0] div);
        int n = 0;
        while (!bus.cmd_ready && n < 50) begin
            step();
            n++;
        end
        check("ready_before_issue", bus.cmd_ready, 1);
        clk_div       = div;
        bus.cmd       = c;
        bus.cmd_din   = d;
        bus.cmd_valid = 1'b1;
        c_acc         = cyc;
        step();
        bus.cmd_valid = 1'b0;
    endtask

    // Record {scl_oe,sda_oe} each cycle from C+1 until a response or the budget runs out.
    task automatic wait_done(input int budget, input int st_at, input int st_len, input int ab_at);
        tr.delete();
        got_rsp  = 1'b0;
        got_arb  = 1'b0;
        got_dout = 1'bx;
        lat      = -1;
        for (int i = 0; i < budget; i++) begin
            int k;
            k = cyc - c_acc;
            scl_ext = !(k >= st_at && k < st_at + st_len);
            if (k == ab_at) enable = 1'b0;
            tr.push_back({scl_oe, sda_oe});
            if (bus.rsp_valid) begin
                got_rsp  = 1'b1;
                got_dout = bus.rsp_dout;
                lat      = k;
            end
            if (bus.arb_lost) begin
                got_arb = 1'b1;
                lat     = k;
            end
            step();
            if (got_rsp || got_arb) break;
        end
        scl_ext = 1'b1;
    endtask

    function automatic logic [1:0] trace_at(int idx);
        if (idx < tr.size()) return tr[idx];
        return 2'bxx;
    endfunction

    task automatic check_quarters(input string tag, input int div,
                                  input logic [1:0] e0, input logic [1:0] e1,
                                  input logic [1:0] e2, input logic [1:0] e3);
        check({tag, "_q0"}, trace_at(0),         e0);
        check({tag, "_q1"}, trace_at(div + 1),   e1);
        check({tag, "_q2"}, trace_at(2*(div+1)), e2);
        check({tag, "_q3"}, trace_at(3*(div+1)), e3);
    endtask

    initial begin
        logic wbits [3];
        wbits = '{1'b0, 1'b1, 1'b0};

        reset         = 1'b1;
        enable        = 1'b1;
        clk_div       = '0;
        scl_ext       = 1'b1;
        sda_ext       = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd       = CMD_START;
        bus.cmd_din   = 1'b0;

        repeat (3) step();
        check("rst_scl_oe",    scl_oe,        0);
        check("rst_sda_oe",    sda_oe,        0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_bus_busy",  bus.bus_busy,  0);
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_arb_lost",  bus.arb_lost,  0);
        #2 reset = 1'b0;
        step();
        check("ready_after_rst", bus.cmd_ready, 1);

        // START then STOP, quarter = 4 cycles
        issue(CMD_START, 1'b0, 16'd3);
        wait_done(40, -1, 0, -1);
        check("start_rsp",  got_rsp, 1);
        check("start_lat",  lat, 17);
        check("start_dout", got_dout, 0);
        check_quarters("start", 3, 2'b00, 2'b00, 2'b01, 2'b11);
        check("start_busy", bus.bus_busy, 1);
        check("rsp_one_cycle", bus.rsp_valid, 0);

        issue(CMD_STOP, 1'b0, 16'd3);
        wait_done(40, -1, 0, -1);
        check("stop_rsp", got_rsp, 1);
        check("stop_lat", lat, 17);
        check_quarters("stop", 3, 2'b11, 2'b01, 2'b01, 2'b00);
        check("stop_busy", bus.bus_busy, 0);

        // WRITE bits 0,1,0 at one cycle per quarter; clk_div change mid-command is ignored
        for (int i = 0; i < 3; i++) begin
            issue(CMD_WRITE, wbits[i], 16'd0);
            if (i == 1) clk_div = 16'd7;
            wait_done(20, -1, 0, -1);
            check($sformatf("wr%0d_rsp", i),  got_rsp, 1);
            check($sformatf("wr%0d_lat", i),  lat, 5);
            check($sformatf("wr%0d_dout", i), got_dout, 0);
            check_quarters($sformatf("wr%0d", i), 0,
                           {1'b1, ~wbits[i]}, {1'b0, ~wbits[i]},
                           {1'b0, ~wbits[i]}, {1'b1, ~wbits[i]});
        end
        check("park_after_write", {scl_oe, sda_oe}, 2'b11);

        // READ with SDA high, then with the slave pulling SDA low
        sda_ext = 1'b1;
        issue(CMD_READ, 1'b0, 16'd0);
        wait_done(20, -1, 0, -1);
        check("rd1_lat",  lat, 5);
        check("rd1_dout", got_dout, 1);
        check_quarters("rd1", 0, 2'b10, 2'b00, 2'b00, 2'b10);
        sda_ext = 1'b0;
        issue(CMD_READ, 1'b0, 16'd0);
        wait_done(20, -1, 0, -1);
        check("rd0_lat",  lat, 5);
        check("rd0_dout", got_dout, 0);
        sda_ext = 1'b1;

        // Slave stretches SCL for 10 cycles at the start of Q1 (C+4..C+13)
        issue(CMD_READ, 1'b0, 16'd2);
        wait_done(60, 4, 10, -1);
        check("stretch_rsp",  got_rsp, 1);
        check("stretch_lat",  lat, 23);
        check("stretch_dout", got_dout, 1);

        // Arbitration loss on WRITE 1 while another master holds SDA low
        issue(CMD_START, 1'b0, 16'd0);
        wait_done(20, -1, 0, -1);
        check("arb_pre_busy", bus.bus_busy, 1);
        sda_ext = 1'b0;
        issue(CMD_WRITE, 1'b1, 16'd0);
        wait_done(20, -1, 0, -1);
        check("arb_seen",     got_arb, 1);
        check("arb_lat",      lat, 4);
        check("arb_no_rsp",   got_rsp, 0);
        check("arb_released", trace_at(3), 2'b00);
        check("arb_busy",     bus.bus_busy, 0);
        wait_done(8, -1, 0, -1);
        check("arb_no_late_rsp", got_rsp, 0);
        check("arb_pulse_once",  got_arb, 0);
        sda_ext = 1'b1;

        // Enable dropped during Q2 of a WRITE 0 (quarter = 2 cycles, Q2 = C+5..C+6)
        issue(CMD_START, 1'b0, 16'd0);
        wait_done(20, -1, 0, -1);
        issue(CMD_WRITE, 1'b0, 16'd1);
        wait_done(20, -1, 0, 5);
        check("abort_no_rsp",    got_rsp, 0);
        check("abort_q2_drive",  trace_at(4), 2'b01);
        check("abort_released",  trace_at(5), 2'b00);
        check("abort_busy",      bus.bus_busy, 0);
        enable = 1'b1;
        step();
        check("abort_ready", bus.cmd_ready, 1);

        // Asynchronous reset in Q0 of a WRITE 0 with the bus busy
        issue(CMD_START, 1'b0, 16'd0);
        wait_done(20, -1, 0, -1);
        issue(CMD_WRITE, 1'b0, 16'd0);
        check("pre_rst_drive", {scl_oe, sda_oe}, 2'b11);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_drive",   {scl_oe, sda_oe}, 2'b00);
        check("mid_rst_busy",    bus.bus_busy,  0);
        check("mid_rst_valid",   bus.rsp_valid, 0);
        check("mid_rst_ready",   bus.cmd_ready, 0);
        check("mid_rst_arb",     bus.arb_lost,  0);
        check("mid_rst_dout",    bus.rsp_dout,  0);
        #2 reset = 1'b0;
        step();
        check("mid_rst_ready_after", bus.cmd_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
